// File: rtl/sfq_pkg.sv
// ============================================================================
// Module      : sfq_pkg
// Description : Shared constants and saturating-add helper for SFQ decoders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sfq_pkg;

    localparam int SFQ_CNT_W   = 8;
    localparam int SFQ_WINDOW  = 16;
    localparam int SFQ_MIN_GAP = 2;

    // Adds inc to a, clamping at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic        inc,
        input int          w
    );
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (inc && (a != max_v)) begin
            sat_add = a + 32'd1;
        end else begin
            sat_add = a;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/sfq_toggle_sync.sv
// ============================================================================
// Module      : sfq_toggle_sync
// Description : Three-flop synchroniser turning a toggle-encoded line into a
//               one-cycle pulse strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfq_toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_p
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // During reset the whole chain tracks din so a static level never
    // looks like an edge once reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= i_din;
            r_s2   <= i_din;
            r_prev <= i_din;
        end else begin
            r_s1   <= i_din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_p = r_s2 ^ r_prev;

endmodule

`default_nettype wire

// File: rtl/sfq_toggle_decoder.sv
// ============================================================================
// Module      : sfq_toggle_decoder
// Description : Recovers SFQ pulses from a toggle-encoded line; per-window
//               pulse count, divide-by-2 toggle output and spacing checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfq_toggle_decoder
    import sfq_pkg::*;
#(
    parameter int CNT_W   = SFQ_CNT_W,
    parameter int WINDOW  = SFQ_WINDOW,
    parameter int MIN_GAP = SFQ_MIN_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    output logic             sat,
    output logic             q,
    output logic             gap_err
);

    localparam int               c_WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int               c_GAP_W   = $clog2(MIN_GAP + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic                 w_p;
    logic                 w_last;
    logic                 w_ovf;
    logic [CNT_W-1:0]     w_acc_inc;

    logic [c_WIN_W-1:0]   r_win;
    logic [CNT_W-1:0]     r_acc;
    logic                 r_satbit;
    logic                 r_h;
    logic [c_GAP_W-1:0]   r_gap;
    logic [CNT_W-1:0]     r_cnt_out;
    logic                 r_cnt_valid;
    logic                 r_sat;
    logic                 r_q;
    logic                 r_gap_err;

    sfq_toggle_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .i_din (din),
        .o_p   (w_p)
    );

    assign w_last    = (r_win == c_WIN_W'(WINDOW - 1));
    assign w_acc_inc = CNT_W'(sat_add(32'(r_acc), w_p, CNT_W));
    assign w_ovf     = w_p && (r_acc == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win       <= '0;
            r_acc       <= '0;
            r_satbit    <= 1'b0;
            r_h         <= 1'b0;
            r_gap       <= c_GAP_W'(MIN_GAP);
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_q         <= 1'b0;
            r_gap_err   <= 1'b0;
        end else begin
            r_win <= w_last ? '0 : r_win + c_WIN_W'(1);

            // A pulse on the closing cycle is folded into the closing window.
            if (w_last) begin
                r_cnt_out   <= w_acc_inc;
                r_sat       <= r_satbit | w_ovf;
                r_cnt_valid <= 1'b1;
                r_acc       <= '0;
                r_satbit    <= 1'b0;
            end else begin
                r_cnt_valid <= 1'b0;
                r_acc       <= w_acc_inc;
                if (w_ovf) begin
                    r_satbit <= 1'b1;
                end
            end

            if (w_p) begin
                r_h <= ~r_h;
                if (r_h) begin
                    r_q <= ~r_q;
                end
            end

            // Gap counter reads (spacing - 1) when the next pulse arrives.
            if (w_p) begin
                if (r_gap < c_GAP_W'(MIN_GAP)) begin
                    r_gap_err <= 1'b1;
                end
                r_gap <= '0;
            end else if (r_gap < c_GAP_W'(MIN_GAP)) begin
                r_gap <= r_gap + c_GAP_W'(1);
            end
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_valid = r_cnt_valid;
    assign sat       = r_sat;
    assign q         = r_q;
    assign gap_err   = r_gap_err;

endmodule

`default_nettype wire

// File: tb/tb_sfq_toggle_decoder.sv
// ============================================================================
// Module      : tb_sfq_toggle_decoder
// Description : Scoreboard bench for sfq_toggle_decoder, default and small
//               saturating configurations side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ps/100fs
`default_nettype none

module tb_sfq_toggle_decoder;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       din0 = 1'b1;
    logic       din1 = 1'b1;
    logic [7:0] cnt0;
    logic       v0, s0, q0, e0;
    logic [2:0] cnt1;
    logic       v1, s1, q1, e1;

    always #10 clk = ~clk;

    sfq_toggle_decoder u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .cnt_out(cnt0), .cnt_valid(v0),
        .sat(s0), .q(q0), .gap_err(e0)
    );

    sfq_toggle_decoder #(.CNT_W(3), .WINDOW(32), .MIN_GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .cnt_out(cnt1), .cnt_valid(v1),
        .sat(s1), .q(q1), .gap_err(e1)
    );

    typedef struct {
        int cnt;
        bit sat;
        bit q;
        bit err;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    bit   hist0[$];
    bit   hist1[$];
    int   c;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t x0, x1;

    // hist[k] is the din level sampled at post-reset edge k (k=0: last reset
    // edge). A level change at edge k is a pulse accounted at edge k+2.
    function automatic exp_t model(input bit h[$], input int n, input int w,
                                   input int mg, input int cw);
        exp_t r;
        int   total;
        int   inwin;
        int   last;
        int   e;
        int   maxv;
        total = 0;
        inwin = 0;
        last  = -1;
        maxv  = (1 << cw) - 1;
        r.err = 1'b0;
        for (int k = 1; k < h.size(); k++) begin
            if (h[k] != h[k-1]) begin
                e = k + 2;
                if (e <= n * w) begin
                    total++;
                    if (e > (n - 1) * w) inwin++;
                    if (last >= 0 && (e - last) <= mg) r.err = 1'b1;
                    last = e;
                end
            end
        end
        r.cnt = (inwin > maxv) ? maxv : inwin;
        r.sat = (inwin > maxv);
        r.q   = ((total / 2) % 2) == 1;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (v0) begin
            if (sb0.size() == 0) begin
                check("dut0 unexpected cnt_valid", 1, 0);
            end else begin
                x0 = sb0.pop_front();
                check("dut0 cnt_out", int'(cnt0), x0.cnt);
                check("dut0 sat", int'(s0), int'(x0.sat));
                check("dut0 q", int'(q0), int'(x0.q));
                check("dut0 gap_err", int'(e0), int'(x0.err));
            end
        end
        if (v1) begin
            if (sb1.size() == 0) begin
                check("dut1 unexpected cnt_valid", 1, 0);
            end else begin
                x1 = sb1.pop_front();
                check("dut1 cnt_out", int'(cnt1), x1.cnt);
                check("dut1 sat", int'(s1), int'(x1.sat));
                check("dut1 q", int'(q1), int'(x1.q));
                check("dut1 gap_err", int'(e1), int'(x1.err));
            end
        end
    end

    task automatic step(input bit d0, input bit d1);
        din0 = d0;
        din1 = d1;
        c++;
        hist0.push_back(d0);
        hist1.push_back(d1);
        if (c % 16 == 0) sb0.push_back(model(hist0, c / 16, 16, 2, 8));
        if (c % 32 == 0) sb1.push_back(model(hist1, c / 32, 32, 1, 3));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst dut0 cnt_out", int'(cnt0), 0);
        check("rst dut0 cnt_valid", int'(v0), 0);
        check("rst dut0 sat", int'(s0), 0);
        check("rst dut0 q", int'(q0), 0);
        check("rst dut0 gap_err", int'(e0), 0);
        check("rst dut1 cnt_out", int'(cnt1), 0);
        check("rst dut1 cnt_valid", int'(v1), 0);
        check("rst dut1 sat", int'(s1), 0);
        check("rst dut1 q", int'(q1), 0);
        check("rst dut1 gap_err", int'(e1), 0);
        rst = 1'b0;
        c   = 0;
        hist0.delete();
        hist1.delete();
        hist0.push_back(din0);
        hist1.push_back(din1);
    endtask

    initial begin
        $monitor("%t rst=%b cnt_valid=%b cnt_out=%0d sat=%b q=%b gap_err=%b",
                 $time, rst, v0, cnt0, s0, q0, e0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Static high din through and after reset.
        do_reset();
        for (int i = 0; i < 32; i++) step(din0, din1);

        // Directed: spaced pulses, closing-cycle pulse, back-to-back pulses;
        // dut1 gets a dense train that saturates its 3-bit count.
        do_reset();
        for (int i = 1; i <= 96; i++) begin
            step(din0 ^ (i inside {1, 4, 7, 10, 13, 30, 50, 51}),
                 din1 ^ ((i <= 19) && (i % 2 == 1)));
        end

        // Reset in the middle of a window, then count only new pulses.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(din0 ^ (i inside {1, 4, 7, 10}), din1 ^ (i inside {1, 4, 7, 10}));
        end
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            step(din0 ^ (i inside {2, 5}), din1 ^ (i inside {2, 5}));
        end

        // Random dense traffic.
        do_reset();
        for (int i = 1; i <= 320; i++) begin
            step(din0 ^ ($urandom_range(3) == 0), din1 ^ ($urandom_range(1) == 0));
        end

        // Random sparse traffic.
        do_reset();
        for (int i = 1; i <= 320; i++) begin
            step(din0 ^ ($urandom_range(7) == 0), din1 ^ ($urandom_range(5) == 0));
        end

        repeat (2) @(negedge clk);
        check("dut0 windows outstanding", sb0.size(), 0);
        check("dut1 windows outstanding", sb1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
